// File: rtl/spi_a2d_mstr.sv
// SPI master for the ADC128S-style A2D: one 16-bit full-duplex transfer per accepted wrt.
// SCLK idles high; MOSI changes on SCLK falls and MISO is sampled just before each rise.
module spi_a2d_mstr #(
   parameter int SCLK_DIV_W = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wrt,
   input  logic [15:0] cmd,
   output logic        done,
   output logic [15:0] rd_data,
   output logic        busy,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   input  logic        MISO
);

   localparam int W = SCLK_DIV_W;
   // LOAD leaves a short high front porch before the ignored first fall
   localparam logic [W-1:0] LOAD = W'(2**(W-1) + 2**(W-2) - 1);
   localparam logic [W-1:0] SMPL = W'(2**(W-1) - 1);
   localparam logic [W-1:0] FALL = '1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t      state, nxt_state;
   logic [W-1:0] div;
   logic [3:0]  bit_cnt;
   logic [15:0] shft;
   logic        miso_smpl;
   logic        first_fall;
   logic        ld, smpl, shft_en, clr_first, fin;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= nxt_state;

   always_comb begin
      nxt_state = state;
      ld        = 1'b0;
      smpl      = 1'b0;
      shft_en   = 1'b0;
      clr_first = 1'b0;
      fin       = 1'b0;
      case (state)
         IDLE:
            if (wrt) begin
               ld        = 1'b1;
               nxt_state = SHIFT;
            end
         SHIFT: begin
            if (div == SMPL) smpl = 1'b1;
            if (div == FALL) begin
               if (first_fall) clr_first = 1'b1;
               else begin
                  shft_en = 1'b1;
                  if (bit_cnt == 4'd15) begin
                     fin       = 1'b1;
                     nxt_state = IDLE;
                  end
               end
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   // Divider free-runs only in SHIFT; reloading on fin suppresses a trailing fall
   always_ff @(posedge clk or posedge rst)
      if (rst)                        div <= '0;
      else if (state == SHIFT && !fin) div <= div + 1'b1;
      else                            div <= LOAD;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         shft       <= '0;
         bit_cnt    <= '0;
         miso_smpl  <= 1'b0;
         first_fall <= 1'b0;
      end else begin
         if (ld) begin
            shft       <= cmd;
            bit_cnt    <= '0;
            first_fall <= 1'b1;
         end else begin
            if (shft_en) begin
               shft    <= {shft[14:0], miso_smpl};
               bit_cnt <= bit_cnt + 1'b1;
            end
            if (clr_first) first_fall <= 1'b0;
         end
         if (smpl) miso_smpl <= MISO;
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         SS_n <= 1'b1;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= fin;
         if (ld) begin
            SS_n <= 1'b0;
            busy <= 1'b1;
         end else if (fin) begin
            SS_n <= 1'b1;
            busy <= 1'b0;
         end
      end

   // Forcing SCLK high in IDLE keeps it high straight out of reset while div is 0
   assign SCLK    = (state == IDLE) | div[W-1];
   assign MOSI    = shft[15];
   assign rd_data = shft;

endmodule

// File: tb/tb_spi_a2d_mstr.sv
// Bench for spi_a2d_mstr: ADC128S-style slave model, transaction-level expectations,
// and free-running monitors on SCLK phase length, idle level and MOSI stability.
module tb_spi_a2d_mstr;

   localparam int W   = 5;
   // done rises on this edge, counting the accepting edge as edge 1
   localparam int LAT = 2**(W-2) + 2 + 16 * 2**W;

   logic        clk = 1'b0;
   logic        rst, wrt, done, busy, SS_n, SCLK, MOSI, MISO;
   logic [15:0] cmd, rd_data;

   int n_chk = 0, n_fail = 0;
   int done_cnt = 0, exp_done = 0;

   spi_a2d_mstr #(.SCLK_DIV_W(W)) dut (
      .clk(clk), .rst(rst), .wrt(wrt), .cmd(cmd), .done(done), .rd_data(rd_data),
      .busy(busy), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Slave model: loads its word on SS_n fall, ignores the first SCLK fall,
   // shifts out on later falls and captures MOSI on rises.
   logic [15:0] a2d_data = '0, tx = '0, rx = '0;
   int          nfall = 0, nrise = 0;
   logic        ss_q = 1'b1, sclk_q = 1'b1, mosi_q = 1'b0;
   assign MISO = tx[15];

   always @(SS_n or SCLK) begin
      if (!SS_n && ss_q) begin
         tx    = a2d_data;
         nfall = 0;
         nrise = 0;
      end else if (!SS_n && !SCLK && sclk_q) begin
         if (nfall > 0) tx = {tx[14:0], 1'b0};
         nfall++;
      end else if (!SS_n && SCLK && !sclk_q) begin
         chk("mosi_stable", 32'(MOSI), 32'(mosi_q));
         rx = {rx[14:0], MOSI};
         nrise++;
      end
      ss_q   = SS_n;
      sclk_q = SCLK;
   end

   // Phase-length and idle-level monitor
   logic sclk_m = 1'b1;
   bit   ph_ok  = 1'b0;
   int   run    = 0;
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (SS_n) begin
         chk("sclk_idle_high", 32'(SCLK), 32'd1);
         ph_ok = 1'b0;
         run   = 0;
      end else if (SCLK != sclk_m) begin
         if (ph_ok) chk("sclk_phase_len", 32'(run), 32'd16);
         if (!SCLK) ph_ok = 1'b1;
         run = 1;
      end else begin
         run++;
      end
      sclk_m = SCLK;
      mosi_q = MOSI;
   end

   task automatic check_idle(input string tag);
      chk({tag, "_ss_n"}, 32'(SS_n), 32'd1);
      chk({tag, "_sclk"}, 32'(SCLK), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_rd"},   32'(rd_data), 32'h0);
   endtask

   // One transaction; optional extra wrt at cycle wrt_at, reset pulse at cycle rst_at
   task automatic txn(input logic [15:0] c, input logic [15:0] d, input int wrt_at, input int rst_at);
      int n;
      bit seen, aborted;
      seen = 0;
      aborted = 0;
      a2d_data = d;
      @(negedge clk);
      wrt = 1'b1;
      cmd = c;
      @(posedge clk); #1;
      wrt = 1'b0;
      cmd = 16'($urandom);
      chk("start_ss_low", 32'(SS_n), 32'd0);
      chk("start_busy", 32'(busy), 32'd1);
      for (n = 1; n < 1000; n++) begin
         @(posedge clk); #1;
         wrt = 1'b0;
         if (done) begin
            seen = 1;
            break;
         end
         chk("busy_held", 32'(busy), 32'd1);
         if (n == wrt_at) begin
            wrt = 1'b1;
            cmd = 16'h5555;
         end
         if (n == rst_at) begin
            rst = 1'b1;
            #1;
            check_idle("rst_mid");
            @(negedge clk);
            rst = 1'b0;
            aborted = 1;
            break;
         end
      end
      if (aborted) begin
         repeat (600) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'(done), 32'd0);
         end
         return;
      end
      chk("latency", 32'(n + 1), 32'(LAT));
      if (seen) begin
         exp_done++;
         chk("rd_data", 32'(rd_data), 32'(d));
         chk("slave_cmd", 32'(rx), 32'(c));
         chk("sclk_rises", 32'(nrise), 32'd16);
         chk("end_ss_high", 32'(SS_n), 32'd1);
         chk("end_busy", 32'(busy), 32'd0);
         @(posedge clk); #1;
         chk("done_one_cycle", 32'(done), 32'd0);
         chk("rd_hold", 32'(rd_data), 32'(d));
      end
   endtask

   // wrt held high: each done cycle is followed directly by the next acceptance
   task automatic back_to_back(input int ntx);
      logic [15:0] c, d;
      int n;
      c = 16'($urandom);
      d = 16'($urandom);
      a2d_data = d;
      @(negedge clk);
      wrt = 1'b1;
      cmd = c;
      @(posedge clk); #1;
      cmd = 16'($urandom);
      for (int k = 0; k < ntx; k++) begin
         chk("b2b_ss_low", 32'(SS_n), 32'd0);
         for (n = 1; n < 1000; n++) begin
            @(posedge clk); #1;
            if (done) break;
         end
         chk("b2b_period", 32'(n + 1), 32'(LAT));
         if (n < 1000) exp_done++;
         chk("b2b_rd_data", 32'(rd_data), 32'(d));
         chk("b2b_slave_cmd", 32'(rx), 32'(c));
         chk("b2b_ss_high", 32'(SS_n), 32'd1);
         c = 16'($urandom);
         d = 16'($urandom);
         a2d_data = d;
         cmd = c;
         if (k == ntx - 1) wrt = 1'b0;
         @(posedge clk); #1;
         cmd = 16'($urandom);
      end
      chk("b2b_stop_idle", 32'(SS_n), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      wrt = 1'b0;
      cmd = '0;
      repeat (3) @(posedge clk);
      #1 check_idle("in_reset");
      @(negedge clk) rst = 1'b0;
      repeat (100) begin
         @(negedge clk);
         check_idle("post_reset");
      end

      txn(16'h1234, 16'hABCD, 0, 0);
      txn(16'hFFFF, 16'h0001, 0, 0);
      txn(16'($urandom), 16'($urandom), 200, 0);
      txn(16'($urandom), 16'($urandom), 0, 300);
      txn(16'hA5A5, 16'($urandom), 0, 0);
      repeat (4) txn(16'($urandom), 16'($urandom), 0, 0);
      back_to_back(4);

      repeat (5) @(negedge clk);
      chk("done_count", 32'(done_cnt), 32'(exp_done));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
